seq_alu: RTL and testbench

Multi-cycle 16-bit arithmetic unit for the matrix-multiplication core. It sits directly upstream of the accumulator register and produces the value that the accumulator loads on its ALU-load path. Operand A comes from the accumulator output and operand B from the data bus. Single-cycle ops complete in one cycle; multiply uses an iterative shift-add datapath, with a start/done handshake to the control unit.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/seq_alu_if.sv | 34 +++
 rtl/mul_shift_add.sv | 60 ++++++
 rtl/seq_alu.sv | 110 +++++++++++
 tb/tb_seq_alu.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared definitions for the sequential ALU: default datapath
//             width, opcode encodings and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_INC   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Purpose  : Control-unit <-> ALU handshake bundle.
//  Signals  : start/op/a/b   request and operands (master -> slave)
//             result/zero    registered result and zero flag (slave -> master)
//             busy/done      status and one-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
interface seq_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, zero, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
//  Module   : mul_shift_add
//  Purpose  : Iterative shift-add multiplier, one multiplier bit per step,
//             LSB first. Keeps the low WIDTH bits of the product.
//  Ports    : clk, rst      clock, synchronous active-high reset
//             load          latch operands, clear product and counter
//             step          perform one iteration
//             a, b          multiplicand / multiplier to load
//             last          current step is the final (WIDTH-th) iteration
//             prod_next     product value after the current step
//  Revision : 1.0  initial release
// ============================================================================
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             step,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  last,
    output logic [WIDTH-1:0]      prod_next
);
    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic [CW-1:0]    r_cnt;

    // Exposed so the final step's sum can be registered into the result on
    // the same edge that completes the iteration.
    assign prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign last      = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (step) begin
            r_prod   <= prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multi-cycle WIDTH-bit ALU feeding the accumulator load path.
//             Single-cycle ops finish in one cycle; MUL runs WIDTH shift-add
//             iterations. All arithmetic is modulo 2^WIDTH.
//  Ports    : clk, rst      clock, synchronous active-high reset
//             bus (slave)   start/op/a/b in; result/zero/busy/done out
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seq_alu_if.slave   bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_prod_next;
    logic             w_last;
    logic             w_load;
    logic             w_step;

    always_comb begin
        w_alu = '0;
        case (bus.op)
            OP_PASSB: w_alu = bus.b;
            OP_ADD:   w_alu = bus.a + bus.b;
            OP_SUB:   w_alu = bus.a - bus.b;
            OP_INC:   w_alu = bus.a + 1'b1;
            OP_SHL:   w_alu = bus.a << 1;
            OP_SHR:   w_alu = bus.a >> 1;
            default:  w_alu = '0;   // OP_MUL handled by the multiplier; OP_RSVD -> 0
        endcase
    end

    assign w_load = (r_state == S_IDLE) && bus.start && (bus.op == OP_MUL);
    assign w_step = (r_state == S_MUL);

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .a         (bus.a),
        .b         (bus.b),
        .last      (w_last),
        .prod_next (w_prod_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.op == OP_MUL) begin
                            r_state <= S_MUL;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_alu;
                            r_zero   <= (w_alu == '0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_result <= w_prod_next;
                        r_zero   <= (w_prod_next == '0);
                        r_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu. Expected results and their
//             completion edge are queued at issue time and popped on done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = a * b;
        case (op)
            3'd0:    return b;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return p[WIDTH-1:0];
            3'd4:    return a + 1'b1;
            3'd5:    return {a[WIDTH-2:0], 1'b0};
            3'd6:    return {1'b0, a[WIDTH-1:1]};
            default: return '0;
        endcase
    endfunction

    // Completion monitor: every done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {16'd0, bus.result}, {16'd0, e.res});
                chk("zero", {31'd0, bus.zero}, {31'd0, (e.res == '0)});
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // Drive one request; returns at the negedge after the sampling edge.
    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.res = model(op, a, b);
        e.at  = cyc + 1 + ((op == OP_MUL) ? WIDTH : 0);
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        if (op == OP_MUL) chk("no_early_done", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("completion_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
        issue(op, a, b);
        wait_idle();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;

        // Wrap-around add, then zero result
        run(OP_ADD, 16'hFFFF, 16'h0002);
        run(OP_SUB, 16'h0005, 16'h0005);

        // Multiplies, including truncation cases
        run(OP_MUL, 16'h0123, 16'h0045);
        chk("mul_literal", {16'd0, bus.result}, 32'h0000_4E6F);
        run(OP_MUL, 16'h0100, 16'h0100);
        run(OP_MUL, 16'hFFFF, 16'hFFFF);
        chk("mul_ffff", {16'd0, bus.result}, 32'h0000_0001);

        // Every opcode with random operands
        for (int i = 0; i < 8; i++) begin
            run(3'(i), 16'($urandom), 16'($urandom));
        end
        run(OP_SHR, 16'h8001, 16'h0000);
        run(OP_SHL, 16'h8001, 16'h0000);

        // Start pulse during MUL must be ignored
        issue(OP_MUL, 16'h1234, 16'h0003);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Reset mid-multiply aborts with no done
        issue(OP_MUL, 16'h00FF, 16'h00FF);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_result", {16'd0, bus.result}, 32'd0);
        chk("abort_zero", {31'd0, bus.zero}, 32'd1);
        repeat (20) @(negedge clk);   // any done here is flagged by the monitor
        run(OP_INC, 16'h7FFF, 16'h0000);
        chk("inc_literal", {16'd0, bus.result}, 32'h0000_8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
